// File: rtl/max_unpooling_if.sv
// ============================================================================
// Module      : max_unpooling_if
// Description : RAM port bundle shared by the unpooling engine and its memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface max_unpooling_if #(
  parameter int memaddrbit = 14,
  parameter int width      = 16
);
  logic [memaddrbit-1:0] memaddr;
  logic [width-1:0]      data_in;
  logic [width-1:0]      data_out;
  logic                  wea;

  modport master (output memaddr, output data_out, output wea, input  data_in);
  modport slave  (input  memaddr, input  data_out, input  wea, output data_in);
endinterface

`default_nettype wire

// File: rtl/max_unpooling.sv
// ============================================================================
// Module      : max_unpooling
// Description : 2x2 max-unpooling engine. Each pooled element is read once and
//               written to its 2x2 output window. Optional macro
//               UNPOOL_ZERO_FILL_EN writes the value to the top-left position
//               only and zeroes the other three.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module max_unpooling #(
  parameter int memaddrbit = 14,
  parameter int width      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [memaddrbit-1:0] dr,
  input  logic [memaddrbit-1:0] dc,
  input  logic [memaddrbit-1:0] di,
  input  logic [memaddrbit-1:0] inaddr,
  input  logic [memaddrbit-1:0] outaddr,
  input  logic                  checkram,
  max_unpooling_if.master       ram,
  output logic [2:0]            state,
  output logic [memaddrbit-1:0] ir,
  output logic [memaddrbit-1:0] ic,
  output logic [memaddrbit-1:0] ii,
  output logic                  picture_finish
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3
  } state_t;

  localparam logic [memaddrbit-1:0] c_one  = {{(memaddrbit-1){1'b0}}, 1'b1};
  localparam logic [memaddrbit-1:0] c_zero = '0;

  state_t                r_state, w_state;
  logic [1:0]            r_cnt, w_cnt;
  logic [width-1:0]      r_buffer, w_buffer;
  logic [memaddrbit-1:0] r_memaddr, w_memaddr;
  logic [width-1:0]      r_data_out, w_data_out;
  logic                  r_wea, w_wea;
  logic [memaddrbit-1:0] r_ir, w_ir;
  logic [memaddrbit-1:0] r_ic, w_ic;
  logic [memaddrbit-1:0] r_ii, w_ii;
  logic                  r_pf, w_pf;

  logic [memaddrbit-1:0] w_rd_addr;
  logic [memaddrbit-1:0] w_wr_addr;
  logic [memaddrbit-1:0] w_dr2;
  logic [memaddrbit-1:0] w_dc2;
  logic [memaddrbit-1:0] w_row;
  logic [memaddrbit-1:0] w_col;
  logic [1:0]            w_kn;
  logic [width-1:0]      w_src;
  logic [width-1:0]      w_fill;
  logic                  w_ic_last;
  logic                  w_ir_last;
  logic                  w_ii_last;

  // Index of the write slot being set up for the next cycle: slot 0 when
  // leaving LOAD, otherwise the one after the current slot.
  assign w_kn = (r_state == ST_LOAD) ? 2'd0 : (r_cnt + 2'd1);

  assign w_dr2 = {dr[memaddrbit-2:0], 1'b0};
  assign w_dc2 = {dc[memaddrbit-2:0], 1'b0};
  assign w_row = {r_ir[memaddrbit-2:0], 1'b0} + {{(memaddrbit-1){1'b0}}, w_kn[1]};
  assign w_col = {r_ic[memaddrbit-2:0], 1'b0} + {{(memaddrbit-1){1'b0}}, w_kn[0]};

  assign w_rd_addr = inaddr + r_ii * dr * dc + r_ir * dc + r_ic;
  assign w_wr_addr = outaddr + r_ii * w_dr2 * w_dc2 + w_row * w_dc2 + w_col;

  // The first write slot is issued on the same edge that fills the buffer,
  // so it takes the RAM data directly.
  assign w_src = (r_state == ST_LOAD) ? ram.data_in : r_buffer;

`ifdef UNPOOL_ZERO_FILL_EN
  assign w_fill = (w_kn == 2'd0) ? w_src : '0;
`else
  assign w_fill = w_src;
`endif

  assign w_ic_last = (r_ic == dc - c_one);
  assign w_ir_last = (r_ir == dr - c_one);
  assign w_ii_last = (r_ii == di - c_one);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 2'd0;
      r_buffer   <= '0;
      r_memaddr  <= '0;
      r_data_out <= '0;
      r_wea      <= 1'b0;
      r_ir       <= '0;
      r_ic       <= '0;
      r_ii       <= '0;
      r_pf       <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_buffer   <= w_buffer;
      r_memaddr  <= w_memaddr;
      r_data_out <= w_data_out;
      r_wea      <= w_wea;
      r_ir       <= w_ir;
      r_ic       <= w_ic;
      r_ii       <= w_ii;
      r_pf       <= w_pf;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_buffer   = r_buffer;
    w_memaddr  = '0;
    w_data_out = '0;
    w_wea      = 1'b0;
    w_ir       = r_ir;
    w_ic       = r_ic;
    w_ii       = r_ii;
    w_pf       = r_pf;

    case (r_state)
      ST_IDLE: begin
        w_cnt = 2'd0;
        w_ir  = c_zero;
        w_ic  = c_zero;
        w_ii  = c_zero;
        w_pf  = 1'b0;
        if (enable) begin
          w_state = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (r_cnt == 2'd3) begin
          w_state    = ST_WRITE;
          w_cnt      = 2'd0;
          w_buffer   = ram.data_in;
          w_memaddr  = w_wr_addr;
          w_wea      = 1'b1;
          w_data_out = w_fill;
        end else begin
          w_cnt     = r_cnt + 2'd1;
          w_memaddr = w_rd_addr;
        end
      end

      ST_WRITE: begin
        if (r_cnt != 2'd3) begin
          w_cnt      = r_cnt + 2'd1;
          w_memaddr  = w_wr_addr;
          w_wea      = 1'b1;
          w_data_out = w_fill;
        end else begin
          w_cnt   = 2'd0;
          w_state = ST_LOAD;
          if (!w_ic_last) begin
            w_ic = r_ic + c_one;
          end else begin
            w_ic = c_zero;
            if (!w_ir_last) begin
              w_ir = r_ir + c_one;
            end else begin
              w_ir = c_zero;
              if (!w_ii_last) begin
                w_ii = r_ii + c_one;
              end else begin
                w_ii    = c_zero;
                w_pf    = 1'b1;
                w_state = checkram ? ST_CHECK : ST_IDLE;
              end
            end
          end
        end
      end

      ST_CHECK: begin
        w_state = ST_CHECK;
      end

      default: begin
        w_state = ST_IDLE;
        w_cnt   = 2'd0;
      end
    endcase
  end

  assign ram.memaddr    = r_memaddr;
  assign ram.data_out   = r_data_out;
  assign ram.wea        = r_wea;
  assign state          = r_state;
  assign ir             = r_ir;
  assign ic             = r_ic;
  assign ii             = r_ii;
  assign picture_finish = r_pf;

endmodule

`default_nettype wire

// File: tb/tb_max_unpooling.sv
// ============================================================================
// Module      : tb_max_unpooling
// Description : Directed self-checking bench for max_unpooling with a
//               two-cycle-latency RAM model and a write logger.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_max_unpooling;

  localparam int AW = 14;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic [AW-1:0] dr = '0, dc = '0, di = '0, inaddr = '0, outaddr = '0;
  logic          checkram = 1'b0;
  logic [2:0]    state;
  logic [AW-1:0] ir, ic, ii;
  logic          picture_finish;

  max_unpooling_if #(.memaddrbit(AW), .width(DW)) bus ();

  max_unpooling #(.memaddrbit(AW), .width(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .dr             (dr),
    .dc             (dc),
    .di             (di),
    .inaddr         (inaddr),
    .outaddr        (outaddr),
    .checkram       (checkram),
    .ram            (bus),
    .state          (state),
    .ir             (ir),
    .ic             (ic),
    .ii             (ii),
    .picture_finish (picture_finish)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem  [0:(1<<AW)-1];
  logic [DW-1:0] wmem [0:(1<<AW)-1];
  logic [DW-1:0] d1, d2;
  int            cyc = 0;
  int            wr_cnt = 0;
  int            last_wr = 0;
  int            bad_wea = 0;
  int            n_assert = 0;
  int            n_fail = 0;
  int            t_en = 0;
  int            base;

  assign bus.data_in = d2;

  always @(posedge clk) begin
    d1  <= mem[bus.memaddr];
    d2  <= d1;
    cyc <= cyc + 1;
    if (bus.wea === 1'b1) begin
      wmem[bus.memaddr] <= bus.data_out;
      wr_cnt            <= wr_cnt + 1;
      last_wr           <= cyc;
    end
  end

  always @(negedge clk) begin
    if ((bus.wea === 1'b1) != (state === 3'd2)) bad_wea <= bad_wea + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] fillv(input logic [DW-1:0] b, input int k);
`ifdef UNPOOL_ZERO_FILL_EN
    return (k == 0) ? b : '0;
`else
    return b;
`endif
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Enable is high for exactly one cycle; returns at the negedge of the next cycle.
  task automatic start();
    @(negedge clk);
    enable = 1'b1;
    t_en   = cyc;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, input string tag);
    for (int i = 0; i < max; i++) begin
      if (state === s) break;
      @(negedge clk);
    end
    check(tag, {29'd0, state}, {29'd0, s});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0010 + 16'(i);
    mem[0] = 16'h0005;

    // Reset state
    step(3);
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_wea", {31'd0, bus.wea}, 32'd0);
    check("rst_memaddr", {18'd0, bus.memaddr}, 32'd0);
    check("rst_dout", {16'd0, bus.data_out}, 32'd0);
    check("rst_pf", {31'd0, picture_finish}, 32'd0);
    check("rst_idx", {18'd0, ir | ic | ii}, 32'd0);
    rst = 1'b1;
    step(2);

    // Single element, outaddr 100
    dr = 14'd1; dc = 14'd1; di = 14'd1; inaddr = 14'd0; outaddr = 14'd100; checkram = 1'b0;
    start();
    check("one_load", {29'd0, state}, 32'd1);
    step(1);
    check("one_rdaddr", {18'd0, bus.memaddr}, 32'd0);
    step(3);
    for (int k = 0; k < 4; k++) begin
      check("one_wea", {31'd0, bus.wea}, 32'd1);
      check("one_addr", {18'd0, bus.memaddr}, 32'd100 + 32'(k));
      check("one_data", {16'd0, bus.data_out}, {16'd0, fillv(16'h0005, k)});
      step(1);
    end
    check("one_wea_off", {31'd0, bus.wea}, 32'd0);
    check("one_idle", {29'd0, state}, 32'd0);

    // 2x2x1 map, element (0,1) reads RAM[1]=0x00AA
    mem[1] = 16'h00AA;
    dr = 14'd2; dc = 14'd2; di = 14'd1; inaddr = 14'd0; outaddr = 14'd0;
    base = wr_cnt;
    start();
    wait_state(3'd0, 200, "sq_done");
    check("sq_count", 32'(wr_cnt - base), 32'd16);
    check("sq_w2", {16'd0, wmem[2]}, {16'd0, fillv(16'h00AA, 0)});
    check("sq_w3", {16'd0, wmem[3]}, {16'd0, fillv(16'h00AA, 1)});
    check("sq_w6", {16'd0, wmem[6]}, {16'd0, fillv(16'h00AA, 2)});
    check("sq_w7", {16'd0, wmem[7]}, {16'd0, fillv(16'h00AA, 3)});
    check("sq_w0", {16'd0, wmem[0]}, {16'd0, fillv(16'h0005, 0)});
    check("sq_w15", {16'd0, wmem[15]}, {16'd0, fillv(16'h0013, 3)});

    // 3x2x2 map: latency and write accounting
    for (int e = 0; e < 12; e++) mem[300 + e] = 16'h0100 + 16'(e);
    dr = 14'd3; dc = 14'd2; di = 14'd2; inaddr = 14'd300; outaddr = 14'd1000;
    base = wr_cnt;
    start();
    wait_state(3'd0, 300, "lat_done");
    check("lat_cycles", 32'(last_wr - t_en + 1), 32'd97);
    check("lat_count", 32'(wr_cnt - base), 32'd48);
    check("lat_w1042", {16'd0, wmem[1042]}, {16'd0, fillv(16'h010B, 0)});
    check("lat_w1047", {16'd0, wmem[1047]}, {16'd0, fillv(16'h010B, 3)});
    check("lat_w1013", {16'd0, wmem[1013]}, {16'd0, fillv(16'h0102, 3)});
    check("lat_bad_wea", 32'(bad_wea), 32'd0);

    // 2x2x3 map parked in CHECK
    for (int e = 0; e < 12; e++) mem[400 + e] = 16'h0200 + 16'(e);
    dr = 14'd2; dc = 14'd2; di = 14'd3; inaddr = 14'd400; outaddr = 14'd2000; checkram = 1'b1;
    base = wr_cnt;
    start();
    wait_state(3'd3, 300, "chk_enter");
    check("chk_count", 32'(wr_cnt - base), 32'd48);
    check("chk_pf", {31'd0, picture_finish}, 32'd1);
    check("chk_w2042", {16'd0, wmem[2042]}, {16'd0, fillv(16'h020B, 0)});
    check("chk_w2047", {16'd0, wmem[2047]}, {16'd0, fillv(16'h020B, 3)});
    base = wr_cnt;
    for (int i = 0; i < 100; i++) begin
      enable = (i % 10 == 0);
      @(negedge clk);
    end
    enable = 1'b0;
    check("chk_hold", {29'd0, state}, 32'd3);
    check("chk_nowr", 32'(wr_cnt - base), 32'd0);
    check("chk_memaddr", {18'd0, bus.memaddr}, 32'd0);
    check("chk_pf_hold", {31'd0, picture_finish}, 32'd1);

    // Reset during WRITE k=1 of element (0,1)
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    dr = 14'd2; dc = 14'd2; di = 14'd1; inaddr = 14'd0; outaddr = 14'd3000; checkram = 1'b0;
    start();
    step(13);
    check("ab_wea_pre", {31'd0, bus.wea}, 32'd1);
    check("ab_addr_pre", {18'd0, bus.memaddr}, 32'd3003);
    rst = 1'b0;
    #1;
    check("ab_wea", {31'd0, bus.wea}, 32'd0);
    check("ab_state", {29'd0, state}, 32'd0);
    step(2);
    rst = 1'b1;
    base = wr_cnt;
    step(10);
    check("ab_nowr", 32'(wr_cnt - base), 32'd0);
    check("ab_idle", {29'd0, state}, 32'd0);
    start();
    step(4);
    check("re_wea", {31'd0, bus.wea}, 32'd1);
    check("re_addr", {18'd0, bus.memaddr}, 32'd3000);
    check("re_idx", {18'd0, ir | ic | ii}, 32'd0);
    check("re_data", {16'd0, bus.data_out}, {16'd0, fillv(16'h0005, 0)});
    wait_state(3'd0, 200, "re_done");
    check("bad_wea", 32'(bad_wea), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
